udp_ack_sender: RTL and testbench
=================================

# udp_ack_sender

Generates a fixed 10-byte UDP status/acknowledge packet on the LiteEth `udp0_sink` stream each time the panel write path reports a completed frame. It sits beside the UDP panel writer: it consumes that writer's frame-complete and error pulses and feeds the Ethernet core's transmit side. This lets the host pace frames and detect loss. Bursts of completions are coalesced into one pending acknowledge; the block never stalls the receive path.

## Interface
- `MAGIC`, default 16'h4C43, first two bytes of every packet ("LC").
- `GAP_CYCLES`, default 16, idle cycles enforced after each packet's last byte (0 allowed).
- `clock`  in  1  system clock (same domain as the Ethernet core and panel writer).
- `resetn`  in  1  reset, asynchronous, active-low.
- `frame_done`  in  1  single-cycle pulse: one frame fully written to the panels.
- `frame_id`  in  16  host frame id, sampled when `frame_done`=1.
- `rx_error`  in  1  single-cycle pulse: a UDP packet was received with error.
- `udp0_sink_valid`  out  1  byte valid toward the Ethernet core.
- `udp0_sink_last`  out  1  marks byte 9.
- `udp0_sink_data`  out  8  packet byte.
- `udp0_sink_ready`  in  1  Ethernet core accepts the byte.
- `busy`  out  1  high in SEND or GAP.

## Operation
- Packet layout, big-endian: bytes 0-1 `MAGIC`; 2-3 latched `frame_id`; 4-5 `frame_count`; 6-7 `error_count`; 8 `coalesced`; 9 XOR of bytes 0-8.
- `frame_count`: 16-bit, +1 per `frame_done`, wraps 0xFFFF→0x0000.
- `error_count`: 16-bit, +1 per `rx_error`, saturates at 0xFFFF.
- `pending`: set by `frame_done`. On each `frame_done`, `frame_id` overwrites the latched id.
- `coalesced`: 8-bit, +1 on a `frame_done` while `pending` is already 1, saturates at 0xFF.
- FSM states:
  - IDLE: if `pending`, snapshot id/counters/`coalesced` into the packet register. In the same edge, clear `pending` and `coalesced`, then go to SEND.
  - SEND: present bytes 0..9 in order. Advance on `valid && ready`. On acceptance of byte 9, go to GAP, or to IDLE if `GAP_CYCLES`=0.
  - GAP: count `GAP_CYCLES` cycles, then go to IDLE.
- The snapshot uses register values before the edge. Events in the snapshot cycle are not in the snapshot; they are counted normally:
  - `frame_done` in the snapshot cycle re-sets `pending`, and `coalesced` becomes 0, not 1.
  - `rx_error` in the snapshot cycle increments `error_count`, visible in the next packet.
- `frame_done` and `rx_error` in the same cycle: both counted.
- Free-running counters (`frame_count`, `error_count`) are never cleared except by reset.

## Timing
- Reset values: `udp0_sink_valid`=0, `udp0_sink_last`=0, `udp0_sink_data`=8'h00, `busy`=0, all counters 0, `pending`=0, state IDLE.
- Latency: `frame_done` at edge N → `pending`=1 after N → snapshot at N+1 → `valid`=1 with byte 0 after N+1. This is 2 cycles when IDLE.
- Stream rule: once `valid` is high, `valid`, `data` and `last` stay stable until `ready`.
  - `valid` never drops mid-packet.
  - `last`=1 only with byte 9.
- `ready` may be held high for the whole packet: 10 bytes in 10 consecutive cycles.
- `ready` low stalls indefinitely. Events during the stall still update counters and `pending`.
- Back-to-back throughput: minimum 10 + `GAP_CYCLES` + 1 cycles per packet.
- Reset mid-packet: outputs clear immediately (asynchronous). The packet is truncated without `last`, and the Ethernet core discards it.

## Structure
- Shared package `ack_pkg`:
  - `ACK_LEN`=10;
  - byte-index constants (`IDX_MAGIC`, `IDX_ID`, `IDX_FCNT`, `IDX_ECNT`, `IDX_COAL`, `IDX_CSUM`);
  - state enum {IDLE, SEND, GAP}.
- Single module, no sub-module.
- The packet is held as a 10-byte snapshot register plus a 4-bit byte index.
- The checksum is computed combinationally from the snapshot and registered at snapshot time.

## Test plan
- `frame_done` with `frame_id`=0x0012 after reset, `ready`=1:
  - `valid` rises 2 cycles later;
  - bytes 4C 43 00 12 00 01 00 00 00 1C;
  - `last` only on 1C;
  - `busy` stays high for 16 GAP cycles.
- `ready` toggled 1/0 pseudo-randomly across a packet: bytes identical to the above, each held stable while `ready`=0.
- Three `frame_done` (ids 5, 6, 7) during one SEND: exactly one follow-up packet after GAP, with id 0x0007, `frame_count` +3, `coalesced`=2.
- `frame_done` in the snapshot cycle: the next packet has `coalesced`=0 and its `frame_count` includes that frame; a second packet follows.
- 70000 `rx_error` pulses then `frame_done`: `error_count` bytes FF FF. 65536 `frame_done` pulses: `frame_count` wraps to 0x0000.
- `resetn` low at byte 4 of a packet:
  - `valid`, `last` and `data` are 0 immediately;
  - no `last` is emitted;
  - after release, `frame_done` gives `frame_count`=0x0001.

Source files
------------

// File: rtl/ack_pkg.sv
// Shared constants, types and helpers for the UDP acknowledge sender.
package ack_pkg;

    // Packet length and byte positions inside the acknowledge packet.
    localparam int ACK_LEN   = 10;
    localparam int IDX_MAGIC = 0;
    localparam int IDX_ID    = 2;
    localparam int IDX_FCNT  = 4;
    localparam int IDX_ECNT  = 6;
    localparam int IDX_COAL  = 8;
    localparam int IDX_CSUM  = 9;

    // Width of the packet body that the checksum covers (bytes 0..8).
    localparam int BODY_W = 8 * (ACK_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } ack_state_e;

    // XOR of all body bytes; byte 0 sits in the most significant position.
    function automatic logic [7:0] ack_csum(input logic [BODY_W-1:0] body);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < ACK_LEN - 1; i++) begin
            acc = acc ^ body[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/udp_ack_sender_if.sv
// Byte stream toward the Ethernet core transmit side (valid/ready with last).
interface udp_ack_sender_if;
    logic       valid;
    logic       last;
    logic [7:0] data;
    logic       ready;

    modport master (
        output valid,
        output last,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  last,
        input  data,
        output ready
    );
endinterface

// File: rtl/udp_ack_sender.sv
// Sends a fixed 10-byte status/acknowledge packet after each completed frame.
// Completions arriving while a packet is pending are coalesced into one packet;
// event inputs are always accepted, so the receive path is never stalled.
module udp_ack_sender
    import ack_pkg::*;
#(
    parameter logic [15:0] MAGIC      = 16'h4C43,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    frame_done,
    input  logic [15:0]             frame_id,
    input  logic                    rx_error,
    udp_ack_sender_if.master        udp0_sink,
    output logic                    busy
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 32'd1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYCLES == 32'd0) ? '0 : GAP_W'(GAP_CYCLES - 32'd1);
    localparam logic [3:0] IDX_LAST = 4'(IDX_CSUM);

    // FSM
    ack_state_e         r_state;
    ack_state_e         w_state_nxt;

    // Event bookkeeping
    logic [15:0]        r_frame_id;
    logic [15:0]        r_frame_count;
    logic [15:0]        r_error_count;
    logic [7:0]         r_coalesced;
    logic               r_pending;

    // Packet snapshot and stream state
    logic [7:0]         r_pkt [ACK_LEN];
    logic [3:0]         r_idx;
    logic               r_valid;
    logic               r_last;
    logic [7:0]         r_data;
    logic               r_busy;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic               w_fire;
    logic               w_last_fire;
    logic               w_snap;
    logic [BODY_W-1:0]  w_body;
    logic [7:0]         w_csum;
    logic [3:0]         w_idx_nxt;
    logic [7:0]         w_byte_nxt;

    assign w_fire      = r_valid & udp0_sink.ready;
    assign w_last_fire = w_fire & (r_idx == IDX_LAST);
    assign w_snap      = (r_state == IDLE) & r_pending;
    assign w_idx_nxt   = r_idx + 4'd1;

    // Snapshot body uses the register values before the snapshot edge, so
    // events arriving in that same cycle land in the following packet.
    assign w_body = {MAGIC, r_frame_id, r_frame_count, r_error_count, r_coalesced};
    assign w_csum = ack_csum(w_body);

    // Next-state logic for the IDLE/SEND/GAP sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (w_last_fire) begin
                    w_state_nxt = (GAP_CYCLES == 32'd0) ? IDLE : GAP;
                end else begin
                    w_state_nxt = SEND;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GAP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Picks the byte that follows the one currently on the bus.
    always_comb begin
        w_byte_nxt = 8'h00;
        case (w_idx_nxt)
            4'd1:    w_byte_nxt = r_pkt[1];
            4'd2:    w_byte_nxt = r_pkt[2];
            4'd3:    w_byte_nxt = r_pkt[3];
            4'd4:    w_byte_nxt = r_pkt[4];
            4'd5:    w_byte_nxt = r_pkt[5];
            4'd6:    w_byte_nxt = r_pkt[6];
            4'd7:    w_byte_nxt = r_pkt[7];
            4'd8:    w_byte_nxt = r_pkt[8];
            4'd9:    w_byte_nxt = r_pkt[9];
            default: w_byte_nxt = 8'h00;
        endcase
    end

    // Free-running frame/error counters, latched frame id and pending flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_frame_count <= 16'h0000;
            r_error_count <= 16'h0000;
            r_frame_id    <= 16'h0000;
            r_pending     <= 1'b0;
        end else begin
            if (frame_done) begin
                r_frame_count <= r_frame_count + 16'h0001;
                r_frame_id    <= frame_id;
            end
            if (rx_error && (r_error_count != 16'hFFFF)) begin
                r_error_count <= r_error_count + 16'h0001;
            end
            // A completion in the snapshot cycle re-arms the next packet.
            if (frame_done) begin
                r_pending <= 1'b1;
            end else if (w_snap) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Coalesce counter: completions merged into an already pending packet.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_coalesced <= 8'h00;
        end else if (w_snap) begin
            r_coalesced <= 8'h00;
        end else if (frame_done && r_pending && (r_coalesced != 8'hFF)) begin
            r_coalesced <= r_coalesced + 8'h01;
        end
    end

    // Packet snapshot register, including the registered checksum.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ACK_LEN; i++) begin
                r_pkt[i] <= 8'h00;
            end
        end else if (w_snap) begin
            r_pkt[IDX_MAGIC]     <= MAGIC[15:8];
            r_pkt[IDX_MAGIC + 1] <= MAGIC[7:0];
            r_pkt[IDX_ID]        <= r_frame_id[15:8];
            r_pkt[IDX_ID + 1]    <= r_frame_id[7:0];
            r_pkt[IDX_FCNT]      <= r_frame_count[15:8];
            r_pkt[IDX_FCNT + 1]  <= r_frame_count[7:0];
            r_pkt[IDX_ECNT]      <= r_error_count[15:8];
            r_pkt[IDX_ECNT + 1]  <= r_error_count[7:0];
            r_pkt[IDX_COAL]      <= r_coalesced;
            r_pkt[IDX_CSUM]      <= w_csum;
        end
    end

    // Stream outputs: load byte 0 at snapshot, advance only on valid && ready.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= 8'h00;
            r_idx   <= 4'd0;
        end else if (w_snap) begin
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_data  <= MAGIC[15:8];
            r_idx   <= 4'd0;
        end else if (w_fire) begin
            if (r_idx == IDX_LAST) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_data  <= 8'h00;
                r_idx   <= 4'd0;
            end else begin
                r_data  <= w_byte_nxt;
                r_last  <= (w_idx_nxt == IDX_LAST);
                r_idx   <= w_idx_nxt;
            end
        end
    end

    // Inter-packet gap counter, restarted by the acceptance of the last byte.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_gap_cnt <= '0;
        end else if (w_last_fire) begin
            r_gap_cnt <= '0;
        end else if (r_state == GAP) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // Busy flag registered from the next state so it tracks SEND and GAP.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
        end
    end

    assign udp0_sink.valid = r_valid;
    assign udp0_sink.last  = r_last;
    assign udp0_sink.data  = r_data;
    assign busy            = r_busy;

endmodule

// File: tb/tb_udp_ack_sender.sv
// Self-checking bench for udp_ack_sender: directed vector table, hand-written
// corner sequences and randomized traffic checked against a behavioural model.
module tb_udp_ack_sender;

    localparam logic [15:0] MAGIC = 16'h4C43;
    localparam int          GAP   = 16;

    logic        clock = 1'b0;
    logic        resetn;
    logic        frame_done;
    logic [15:0] frame_id;
    logic        rx_error;
    logic        busy;

    udp_ack_sender_if snk ();

    udp_ack_sender #(.MAGIC(MAGIC), .GAP_CYCLES(GAP)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_done (frame_done),
        .frame_id   (frame_id),
        .rx_error   (rx_error),
        .udp0_sink  (snk),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_k, m_fcnt, m_ecnt, m_coal, m_id, m_byte;
    int          m_ready_at, m_gap_lo, m_gap_hi;
    bit          m_pend, m_in;
    logic [79:0] m_exp;

    // Captured packets (byte 0 in the top byte)
    logic [79:0] pkts [$];
    logic [79:0] cur;
    int          nb;

    typedef struct {
        logic [15:0] id;
        int          nerr;
        logic [79:0] exp;
    } vec_t;
    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pb(input logic [79:0] p, input int i);
        return p[79 - 8*i -: 8];
    endfunction

    function automatic logic [79:0] build_pkt(input int id, input int fc, input int ec, input int co);
        logic [71:0] body;
        logic [7:0]  x;
        body = {MAGIC, id[15:0], fc[15:0], ec[15:0], co[7:0]};
        x = 8'h00;
        for (int i = 0; i < 9; i++) x = x ^ body[8*i +: 8];
        return {body, x};
    endfunction

    task automatic model_reset();
        m_fcnt = 0; m_ecnt = 0; m_coal = 0; m_id = 0; m_byte = 0;
        m_pend = 0; m_in = 0; m_ready_at = 0; m_gap_lo = 1; m_gap_hi = 0;
        m_exp = '0;
        pkts.delete(); cur = '0; nb = 0;
    endtask

    // One clock: apply inputs, advance the model across the edge, compare.
    task automatic step(input logic fd, input logic [15:0] id, input logic er, input logic rd);
        bit start;
        frame_done = fd; frame_id = id; rx_error = er; snk.ready = rd;
        if (snk.valid === 1'b1 && rd) begin
            cur = {cur[71:0], snk.data};
            nb++;
            if (snk.last === 1'b1) begin
                pkts.push_back(cur);
                nb = 0;
            end
        end
        m_k++;
        start = !m_in && m_pend && (m_k >= m_ready_at);
        if (m_in && rd) begin
            if (m_byte == 9) begin
                m_in = 0; m_gap_lo = m_k; m_gap_hi = m_k + GAP - 1; m_ready_at = m_k + GAP + 1;
            end else begin
                m_byte++;
            end
        end
        if (start) begin
            m_exp = build_pkt(m_id, m_fcnt, m_ecnt, m_coal);
            m_in = 1; m_byte = 0; m_pend = 0; m_coal = 0;
        end
        if (fd) begin
            if (m_pend && m_coal < 255) m_coal++;
            m_pend = 1; m_id = id; m_fcnt = (m_fcnt + 1) % 65536;
        end
        if (er && m_ecnt < 65535) m_ecnt++;
        @(posedge clock);
        #1;
        chk("valid", snk.valid, m_in);
        chk("last", snk.last, (m_in && m_byte == 9));
        if (m_in) chk("data", snk.data, pb(m_exp, m_byte));
        chk("busy", busy, (m_in || (m_k >= m_gap_lo && m_k <= m_gap_hi)));
    endtask

    task automatic wait_pkts(input int n, input int budget);
        int b = 0;
        while (pkts.size() < n && b < budget) begin
            step(1'b0, 16'h0000, 1'b0, 1'b1);
            b++;
        end
        chk("pkt_timeout", (pkts.size() >= n), 1);
    endtask

    task automatic do_reset();
        resetn = 1'b0; frame_done = 1'b0; rx_error = 1'b0; frame_id = 16'h0000; snk.ready = 1'b0;
        #10;
        model_reset();
        resetn = 1'b1;
        chk("rst_valid", snk.valid, 0);
        chk("rst_last", snk.last, 0);
        chk("rst_data", snk.data, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        logic [79:0] p;
        int bc;
        int b;
        m_k = 0;
        resetn = 1'b0; frame_done = 1'b0; rx_error = 1'b0; frame_id = 16'h0000; snk.ready = 1'b0;
        model_reset();
        #6;

        vecs[0] = '{id: 16'h0012, nerr: 0, exp: 80'h4C43_0012_0001_0000_00_1C};
        vecs[1] = '{id: 16'hABCD, nerr: 3, exp: 80'h4C43_ABCD_0001_0003_00_6B};
        vecs[2] = '{id: 16'hFFFF, nerr: 2, exp: 80'h4C43_FFFF_0001_0002_00_0C};

        // Directed vector table: latency, exact bytes and gap length.
        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int e = 0; e < vecs[v].nerr; e++) step(1'b0, 16'h0000, 1'b1, 1'b1);
            step(1'b1, vecs[v].id, 1'b0, 1'b1);
            chk("lat_1cyc_valid", snk.valid, 0);
            step(1'b0, 16'h0000, 1'b0, 1'b1);
            chk("lat_2cyc_valid", snk.valid, 1);
            wait_pkts(1, 40);
            if (pkts.size() > 0) begin
                for (int i = 0; i < 10; i++) chk($sformatf("vec%0d_byte%0d", v, i), pb(pkts[0], i), pb(vecs[v].exp, i));
            end
            bc = busy ? 1 : 0;
            for (int c = 0; c < 20; c++) begin
                step(1'b0, 16'h0000, 1'b0, 1'b1);
                if (busy) bc++;
            end
            chk("gap_busy_cycles", bc, GAP);
        end

        // Ready toggled pseudo-randomly across a packet.
        do_reset();
        step(1'b1, 16'h0012, 1'b0, 1'b1);
        b = 0;
        while (pkts.size() < 1 && b < 300) begin
            step(1'b0, 16'h0000, 1'b0, 1'($urandom_range(0, 1)));
            b++;
        end
        chk("toggle_timeout", (pkts.size() >= 1), 1);
        if (pkts.size() > 0) chk("toggle_pkt_lo", pkts[0][31:0], vecs[0].exp[31:0]);
        if (pkts.size() > 0) chk("toggle_pkt_hi", pkts[0][79:32], vecs[0].exp[79:32]);

        // Three completions during one SEND coalesce into one follow-up packet.
        do_reset();
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0005, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0006, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0007, 1'b0, 1'b1);
        wait_pkts(2, 200);
        for (int c = 0; c < 60; c++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("coal_pkt_count", pkts.size(), 2);
        if (pkts.size() > 1) begin
            chk("coal_id", {pb(pkts[1], 2), pb(pkts[1], 3)}, 16'h0007);
            chk("coal_fcnt", {pb(pkts[1], 4), pb(pkts[1], 5)}, 16'h0004);
            chk("coal_coal", pb(pkts[1], 8), 8'h02);
        end

        // Completion and error in the snapshot cycle go to the next packet.
        do_reset();
        step(1'b1, 16'h0021, 1'b0, 1'b1);
        step(1'b1, 16'h0022, 1'b1, 1'b1);
        wait_pkts(2, 200);
        if (pkts.size() > 1) begin
            chk("snap_p0_fcnt", {pb(pkts[0], 4), pb(pkts[0], 5)}, 16'h0001);
            chk("snap_p0_ecnt", {pb(pkts[0], 6), pb(pkts[0], 7)}, 16'h0000);
            chk("snap_p1_id", {pb(pkts[1], 2), pb(pkts[1], 3)}, 16'h0022);
            chk("snap_p1_fcnt", {pb(pkts[1], 4), pb(pkts[1], 5)}, 16'h0002);
            chk("snap_p1_ecnt", {pb(pkts[1], 6), pb(pkts[1], 7)}, 16'h0001);
            chk("snap_p1_coal", pb(pkts[1], 8), 8'h00);
        end

        // Flood: counter wrap, error saturation, coalesce saturation under stall.
        do_reset();
        for (int c = 0; c < 65535; c++) step(1'b1, 16'hBEEF, 1'b1, (c >= 400));
        for (int c = 0; c < 60; c++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        if (pkts.size() > 1) chk("coal_saturate", pb(pkts[1], 8), 8'hFF);
        pkts.delete();
        step(1'b1, 16'h0042, 1'b1, 1'b1);
        wait_pkts(1, 60);
        if (pkts.size() > 0) begin
            chk("wrap_fcnt", {pb(pkts[0], 4), pb(pkts[0], 5)}, 16'h0000);
            chk("sat_ecnt", {pb(pkts[0], 6), pb(pkts[0], 7)}, 16'hFFFF);
        end

        // Reset while byte 4 is on the bus.
        do_reset();
        step(1'b1, 16'h0055, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("mid_bytes_taken", nb, 4);
        chk("mid_no_last", pkts.size(), 0);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", snk.valid, 0);
        chk("mid_rst_last", snk.last, 0);
        chk("mid_rst_data", snk.data, 0);
        @(posedge clock);
        #1;
        model_reset();
        resetn = 1'b1;
        step(1'b1, 16'h0066, 1'b0, 1'b1);
        wait_pkts(1, 40);
        if (pkts.size() > 0) chk("post_rst_fcnt", {pb(pkts[0], 4), pb(pkts[0], 5)}, 16'h0001);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 6) == 0, 16'($urandom), ($urandom % 5) == 0, ($urandom % 3) != 0);
        end
        b = 0;
        while ((m_in || m_pend) && b < 500) begin
            step(1'b0, 16'h0000, 1'b0, 1'b1);
            b++;
        end
        chk("drain_timeout", (m_in || m_pend), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
